// File: rtl/cu_rf_scoreboard.sv
// Register file with busy/pending scoreboard, bus-connect write port and per-FU result arbitration.
// Optional forwarding of the register being written this cycle: define CU_RF_BYPASS_EN.
module cu_rf_scoreboard #(
  parameter int RF_DATASIZE   = 16,
  parameter int ADDRESS_WIDTH = 4,
  parameter int NUM_FU        = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps_iss_vld,
  input  logic [NUM_FU-1:0]             ps_iss_fu,
  input  logic [ADDRESS_WIDTH-1:0]      ps_raddx,
  input  logic [ADDRESS_WIDTH-1:0]      ps_raddy,
  input  logic [ADDRESS_WIDTH-1:0]      ps_wadd,
  output logic                          cu_ps_stall,
  output logic                          cu_ps_idle,
  output logic [RF_DATASIZE-1:0]        xb_dtx,
  output logic [RF_DATASIZE-1:0]        xb_dty,
  input  logic [NUM_FU-1:0]             fu_xb_vld,
  input  logic [NUM_FU*RF_DATASIZE-1:0] fu_xb_dt,
  output logic [NUM_FU-1:0]             xb_fu_rdy,
  input  logic                          ps_bc_wen,
  input  logic [ADDRESS_WIDTH-1:0]      ps_bc_wadd,
  input  logic [RF_DATASIZE-1:0]        bc_dt,
  output logic                          xb_bc_rdy
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  logic [RF_DATASIZE-1:0]   regs      [DEPTH];
  logic [DEPTH-1:0]         busy;
  logic [NUM_FU-1:0]        pending;
  logic [ADDRESS_WIDTH-1:0] pend_addr [NUM_FU];

  logic                     bc_acc;
  logic [NUM_FU-1:0]        fu_grant;
  logic                     wr_en;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic [RF_DATASIZE-1:0]   wr_data;
  logic [DEPTH-1:0]         busy_eff;
  logic [DEPTH-1:0]         busy_next;
  logic [NUM_FU-1:0]        pending_next;
  logic                     fu_onehot;
  logic                     pend_sel;
  logic                     issue_acc;

  assign bc_acc    = ps_bc_wen & ~busy[ps_bc_wadd];
  assign xb_bc_rdy = bc_acc;

  // Single write port: bus-connect first, else the lowest-index FU holding a real result.
  always_comb begin
    fu_grant = '0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    if (bc_acc) begin
      wr_en   = 1'b1;
      wr_addr = ps_bc_wadd;
      wr_data = bc_dt;
    end else begin
      for (int i = NUM_FU - 1; i >= 0; i--) begin
        if (fu_xb_vld[i] && pending[i]) begin
          fu_grant    = '0;
          fu_grant[i] = 1'b1;
          wr_en       = 1'b1;
          wr_addr     = pend_addr[i];
          wr_data     = fu_xb_dt[i*RF_DATASIZE +: RF_DATASIZE];
        end
      end
    end
  end

  // Results from an FU with nothing outstanding are acknowledged and dropped.
  assign xb_fu_rdy = fu_grant | (fu_xb_vld & ~pending);

`ifdef CU_RF_BYPASS_EN
  logic [DEPTH-1:0] wr_mask;

  always_comb begin
    wr_mask          = '0;
    wr_mask[wr_addr] = wr_en;
    busy_eff         = busy & ~wr_mask;
    xb_dtx           = (wr_en && (wr_addr == ps_raddx)) ? wr_data : regs[ps_raddx];
    xb_dty           = (wr_en && (wr_addr == ps_raddy)) ? wr_data : regs[ps_raddy];
  end
`else
  always_comb begin
    busy_eff = busy;
    xb_dtx   = regs[ps_raddx];
    xb_dty   = regs[ps_raddy];
  end
`endif

  assign fu_onehot = (ps_iss_fu != '0) && ((ps_iss_fu & (ps_iss_fu - NUM_FU'(1))) == '0);
  assign pend_sel  = |(pending & ps_iss_fu);

  assign cu_ps_stall = ps_iss_vld & (busy_eff[ps_raddx] | busy_eff[ps_raddy] |
                                     busy_eff[ps_wadd] | pend_sel | ~fu_onehot);
  assign issue_acc   = ps_iss_vld & ~cu_ps_stall;
  assign cu_ps_idle  = ~(|busy) & ~(|pending);

  // A new issue's busy set is applied after the writeback clear so it wins on the same address.
  always_comb begin
    busy_next = busy;
    if (|fu_grant) busy_next[wr_addr] = 1'b0;
    if (issue_acc) busy_next[ps_wadd] = 1'b1;
    pending_next = (pending & ~fu_grant) | (issue_acc ? ps_iss_fu : '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      for (int i = 0; i < NUM_FU; i++) pend_addr[i] <= '0;
      busy    <= '0;
      pending <= '0;
    end else begin
      if (wr_en) regs[wr_addr] <= wr_data;
      for (int i = 0; i < NUM_FU; i++) begin
        if (issue_acc && ps_iss_fu[i]) pend_addr[i] <= ps_wadd;
      end
      busy    <= busy_next;
      pending <= pending_next;
    end
  end

endmodule

// File: tb/tb_cu_rf_scoreboard.sv
// Self-checking bench for cu_rf_scoreboard: directed vector table, hand sequences, randomized run vs reference model.
module tb_cu_rf_scoreboard;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NF = 3;

`ifdef CU_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ps_iss_vld;
  logic [NF-1:0] ps_iss_fu;
  logic [AW-1:0] ps_raddx, ps_raddy, ps_wadd;
  logic          cu_ps_stall, cu_ps_idle;
  logic [DW-1:0] xb_dtx, xb_dty;
  logic [NF-1:0] fu_xb_vld;
  logic [NF*DW-1:0] fu_xb_dt;
  logic [NF-1:0] xb_fu_rdy;
  logic          ps_bc_wen;
  logic [AW-1:0] ps_bc_wadd;
  logic [DW-1:0] bc_dt;
  logic          xb_bc_rdy;

  cu_rf_scoreboard #(.RF_DATASIZE(DW), .ADDRESS_WIDTH(AW), .NUM_FU(NF)) dut (
    .clk(clk), .reset(reset),
    .ps_iss_vld(ps_iss_vld), .ps_iss_fu(ps_iss_fu),
    .ps_raddx(ps_raddx), .ps_raddy(ps_raddy), .ps_wadd(ps_wadd),
    .cu_ps_stall(cu_ps_stall), .cu_ps_idle(cu_ps_idle),
    .xb_dtx(xb_dtx), .xb_dty(xb_dty),
    .fu_xb_vld(fu_xb_vld), .fu_xb_dt(fu_xb_dt), .xb_fu_rdy(xb_fu_rdy),
    .ps_bc_wen(ps_bc_wen), .ps_bc_wadd(ps_bc_wadd), .bc_dt(bc_dt),
    .xb_bc_rdy(xb_bc_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          iss_vld;
    logic [2:0]    iss_fu;
    logic [3:0]    x, y, w;
    logic [2:0]    fvld;
    logic [15:0]   d0, d1, d2;
    logic          bc_wen;
    logic [3:0]    bc_a;
    logic [15:0]   bc_d;
    logic          e_stall, e_idle;
    logic [15:0]   e_dtx, e_dty;
    logic [2:0]    e_rdy;
    logic          e_bc;
  } vec_t;

  vec_t tbl[17];
  int checks = 0;
  int failures = 0;

  function automatic vec_t mk(logic iv, logic [2:0] fu, logic [3:0] x, logic [3:0] y, logic [3:0] w,
                              logic [2:0] fv, logic [15:0] d0, logic [15:0] d1, logic [15:0] d2,
                              logic bw, logic [3:0] ba, logic [15:0] bd,
                              logic es, logic ei, logic [15:0] ex, logic [15:0] ey,
                              logic [2:0] er, logic eb);
    vec_t v;
    v.iss_vld = iv; v.iss_fu = fu; v.x = x; v.y = y; v.w = w;
    v.fvld = fv; v.d0 = d0; v.d1 = d1; v.d2 = d2;
    v.bc_wen = bw; v.bc_a = ba; v.bc_d = bd;
    v.e_stall = es; v.e_idle = ei; v.e_dtx = ex; v.e_dty = ey; v.e_rdy = er; v.e_bc = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ps_iss_vld = v.iss_vld; ps_iss_fu = v.iss_fu;
    ps_raddx = v.x; ps_raddy = v.y; ps_wadd = v.w;
    fu_xb_vld = v.fvld; fu_xb_dt = {v.d2, v.d1, v.d0};
    ps_bc_wen = v.bc_wen; ps_bc_wadd = v.bc_a; bc_dt = v.bc_d;
  endtask

  task automatic idle_inputs();
    drive(mk(0, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic check_outs(input string tag, input logic es, input logic ei, input logic [15:0] ex,
                            input logic [15:0] ey, input logic [2:0] er, input logic eb);
    chk({tag, ".stall"}, cu_ps_stall, es);
    chk({tag, ".idle"},  cu_ps_idle,  ei);
    chk({tag, ".dtx"},   xb_dtx,      ex);
    chk({tag, ".dty"},   xb_dty,      ey);
    chk({tag, ".fu_rdy"}, xb_fu_rdy,  er);
    chk({tag, ".bc_rdy"}, xb_bc_rdy,  eb);
  endtask

  // Reference model state
  logic [15:0] m_regs [16];
  logic        m_busy [16];
  logic        m_pend [3];
  logic [3:0]  m_paddr[3];
  logic        fv [3];
  logic [15:0] fd [3];
  bit          wr;
  int          waddr;
  logic [15:0] wdat;

  function automatic bit seen_busy(input int a);
    return m_busy[a] && !(BYP && wr && waddr == a);
  endfunction

  function automatic logic [15:0] seen_data(input int a);
    if (BYP && wr && waddr == a) return wdat;
    return m_regs[a];
  endfunction

  initial begin
    // Rows run back-to-back from reset; register contents carry over between rows.
    tbl[0]  = mk(0, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0,             0, 0, 0,          0, 1, 0, 0, 3'b000, 0);
    tbl[1]  = mk(0, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0,             1, 3, 16'h1234,   0, 1, 0, 0, 3'b000, 1);
    tbl[2]  = mk(0, 3'b000, 3, 0, 0, 3'b000, 0, 0, 0,             0, 0, 0,          0, 1, 16'h1234, 0, 3'b000, 0);
    tbl[3]  = mk(1, 3'b001, 3, 0, 1, 3'b000, 0, 0, 0,             0, 0, 0,          0, 1, 16'h1234, 0, 3'b000, 0);
    tbl[4]  = mk(1, 3'b001, 3, 3, 2, 3'b000, 0, 0, 0,             0, 0, 0,          1, 0, 16'h1234, 16'h1234, 3'b000, 0);
    tbl[5]  = mk(1, 3'b100, 0, 0, 4, 3'b000, 0, 0, 0,             0, 0, 0,          0, 0, 0, 0, 3'b000, 0);
    tbl[6]  = mk(1, 3'b001, 0, 0, 2, 3'b101, 16'h1111, 0, 16'h2222, 1, 6, 16'h6666, 1, 0, 0, 0, 3'b000, 1);
    tbl[7]  = mk(1, 3'b001, 6, 3, 2, 3'b101, 16'h1111, 0, 16'h2222, 0, 0, 0,        1, 0, 16'h6666, 16'h1234, 3'b001, 0);
    tbl[8]  = mk(1, 3'b001, 1, 0, 2, 3'b100, 0, 0, 16'h2222,      0, 0, 0,          0, 0, 16'h1111, 0, 3'b100, 0);
    tbl[9]  = mk(0, 3'b000, 4, 6, 0, 3'b000, 0, 0, 0,             1, 2, 16'h9999,   0, 0, 16'h2222, 16'h6666, 3'b000, 0);
    tbl[10] = mk(0, 3'b000, 4, 0, 0, 3'b011, 16'h3333, 16'hDEAD, 0, 0, 0, 0,        0, 0, 16'h2222, 0, 3'b011, 0);
    tbl[11] = mk(1, 3'b011, 2, 1, 8, 3'b000, 0, 0, 0,             0, 0, 0,          1, 1, 16'h3333, 16'h1111, 3'b000, 0);
    tbl[12] = mk(1, 3'b000, 2, 1, 8, 3'b000, 0, 0, 0,             0, 0, 0,          1, 1, 16'h3333, 16'h1111, 3'b000, 0);
    tbl[13] = mk(1, 3'b010, 0, 0, 9, 3'b000, 0, 0, 0,             0, 0, 0,          0, 1, 0, 0, 3'b000, 0);
    tbl[14] = mk(1, 3'b100, 0, 0, 9, 3'b000, 0, 0, 0,             0, 0, 0,          1, 0, 0, 0, 3'b000, 0);
    tbl[15] = mk(0, 3'b000, 0, 0, 0, 3'b010, 0, 16'h0099, 0,      0, 0, 0,          0, 0, 0, 0, 3'b010, 0);
    tbl[16] = mk(0, 3'b000, 9, 0, 0, 3'b000, 0, 0, 0,             0, 0, 0,          0, 1, 16'h0099, 0, 3'b000, 0);

    idle_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_outs("reset", 0, 1, 0, 0, 3'b000, 0);
    @(negedge clk) reset = 1'b1;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1 check_outs($sformatf("vec%0d", i), tbl[i].e_stall, tbl[i].e_idle, tbl[i].e_dtx,
                    tbl[i].e_dty, tbl[i].e_rdy, tbl[i].e_bc);
    end

    // RAW on a register owned by FU1
    @(negedge clk);
    drive(mk(1, 3'b010, 0, 0, 5, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 chk("raw.issue1_stall", cu_ps_stall, 0);
    @(negedge clk);
    drive(mk(1, 3'b001, 0, 5, 8, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 chk("raw.wait_stall", cu_ps_stall, 1);
    @(negedge clk);
    drive(mk(1, 3'b001, 0, 5, 8, 3'b010, 0, 16'h00AA, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("raw.grant_rdy", xb_fu_rdy, 3'b010);
`ifdef CU_RF_BYPASS_EN
    chk("raw.grant_stall", cu_ps_stall, 0);
    chk("raw.grant_dty", xb_dty, 16'h00AA);
`else
    chk("raw.grant_stall", cu_ps_stall, 1);
    chk("raw.grant_dty", xb_dty, 16'h0000);
    @(negedge clk);
    drive(mk(1, 3'b001, 0, 5, 8, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 chk("raw.after_stall", cu_ps_stall, 0);
    chk("raw.after_dty", xb_dty, 16'h00AA);
`endif
    @(negedge clk);
    drive(mk(0, 3'b000, 8, 0, 0, 3'b001, 16'h0808, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 chk("raw.fu0_rdy", xb_fu_rdy, 3'b001);
    @(negedge clk);
    idle_inputs();
    ps_raddx = 4'd8;
    #1 chk("raw.r8", xb_dtx, 16'h0808);
    chk("raw.idle", cu_ps_idle, 1);

    // Reset while FU2 owns r7; the late result is then dropped
    @(negedge clk);
    drive(mk(1, 3'b100, 0, 0, 7, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 chk("rst.issue_stall", cu_ps_stall, 0);
    @(negedge clk);
    idle_inputs();
    #1 chk("rst.busy_idle", cu_ps_idle, 0);
    reset = 1'b0;
    #1 chk("rst.async_idle", cu_ps_idle, 1);
    chk("rst.async_dtx", xb_dty, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    drive(mk(0, 3'b000, 7, 0, 0, 3'b100, 0, 0, 16'hBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 chk("rst.late_rdy", xb_fu_rdy, 3'b100);
    chk("rst.late_idle", cu_ps_idle, 1);
    @(negedge clk);
    idle_inputs();
    ps_raddx = 4'd7;
    #1 chk("rst.r7", xb_dtx, 16'h0000);
    chk("rst.idle", cu_ps_idle, 1);

    // Randomized run against the reference model (everything is zero after the reset above)
    for (int i = 0; i < 16; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
    for (int i = 0; i < 3; i++) begin m_pend[i] = 1'b0; m_paddr[i] = '0; fv[i] = 1'b0; fd[i] = '0; end

    for (int cyc = 0; cyc < 3000; cyc++) begin
      int g;
      int fidx;
      logic [2:0] e_rdy;
      logic e_stall, e_idle, e_bc, sel_pend;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!fv[i] && $urandom_range(0, 2) == 0) begin
          fv[i] = 1'b1;
          fd[i] = 16'($urandom);
        end
      end
      ps_iss_vld = 1'($urandom_range(0, 1));
      fidx = $urandom_range(0, 9);
      ps_iss_fu = (fidx < 9) ? 3'(1 << (fidx % 3)) : 3'($urandom_range(0, 7));
      ps_raddx = 4'($urandom_range(0, 7));
      ps_raddy = 4'($urandom_range(0, 7));
      ps_wadd = 4'($urandom_range(0, 7));
      ps_bc_wen = ($urandom_range(0, 3) == 0);
      ps_bc_wadd = 4'($urandom_range(0, 7));
      bc_dt = 16'($urandom);
      fu_xb_vld = {fv[2], fv[1], fv[0]};
      fu_xb_dt = {fd[2], fd[1], fd[0]};
      #1;

      wr = 1'b0; waddr = 0; wdat = '0; g = -1;
      if (ps_bc_wen && !m_busy[ps_bc_wadd]) begin
        wr = 1'b1; waddr = int'(ps_bc_wadd); wdat = bc_dt;
      end else begin
        for (int i = 0; i < 3; i++) if (g < 0 && fv[i] && m_pend[i]) g = i;
        if (g >= 0) begin wr = 1'b1; waddr = int'(m_paddr[g]); wdat = fd[g]; end
      end
      e_bc = ps_bc_wen && !m_busy[ps_bc_wadd];
      for (int i = 0; i < 3; i++) e_rdy[i] = (fv[i] && !m_pend[i]) || (g == i);
      sel_pend = 1'b0;
      for (int i = 0; i < 3; i++) if (ps_iss_fu[i] && m_pend[i]) sel_pend = 1'b1;
      e_stall = ps_iss_vld && (seen_busy(ps_raddx) || seen_busy(ps_raddy) || seen_busy(ps_wadd) ||
                               sel_pend || ($countones(ps_iss_fu) != 1));
      e_idle = 1'b1;
      for (int i = 0; i < 16; i++) if (m_busy[i]) e_idle = 1'b0;
      for (int i = 0; i < 3; i++) if (m_pend[i]) e_idle = 1'b0;

      check_outs($sformatf("rnd%0d", cyc), e_stall, e_idle, seen_data(ps_raddx),
                 seen_data(ps_raddy), e_rdy, e_bc);

      if (wr) m_regs[waddr] = wdat;
      if (g >= 0) begin m_busy[m_paddr[g]] = 1'b0; m_pend[g] = 1'b0; end
      if (ps_iss_vld && !e_stall) begin
        for (int i = 0; i < 3; i++) begin
          if (ps_iss_fu[i]) begin m_pend[i] = 1'b1; m_paddr[i] = ps_wadd; end
        end
        m_busy[ps_wadd] = 1'b1;
      end
      for (int i = 0; i < 3; i++) if (e_rdy[i]) fv[i] = 1'b0;
    end

    @(negedge clk);
    idle_inputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cu_rf_scoreboard.md
CU_RF_SCOREBOARD -- requirements
Module: cu_rf_scoreboard

Interface
REQ-001 SHALL have parameter RF_DATASIZE, default 16, register and datapath width in bits.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 4, register address width; depth is 2**ADDRESS_WIDTH.
REQ-003 SHALL have parameter NUM_FU, default 3, number of functional-unit result channels (bit 0 highest priority).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 ps_iss_vld  in  1  PS presents an instruction this cycle.
REQ-007 ps_iss_fu  in  NUM_FU  one-hot target functional unit.
REQ-008 ps_raddx  in  ADDRESS_WIDTH  operand X read address.
REQ-009 ps_raddy  in  ADDRESS_WIDTH  operand Y read address.
REQ-010 ps_wadd  in  ADDRESS_WIDTH  destination register.
REQ-011 cu_ps_stall  out  1  issue refused this cycle.
REQ-012 cu_ps_idle  out  1  no register busy and no FU pending.
REQ-013 xb_dtx  out  RF_DATASIZE  operand X data, combinational.
REQ-014 xb_dty  out  RF_DATASIZE  operand Y data, combinational.
REQ-015 fu_xb_vld  in  NUM_FU  per-FU result valid, held until accepted.
REQ-016 fu_xb_dt  in  NUM_FU*RF_DATASIZE  flattened results, FU i at bits [i*RF_DATASIZE +: RF_DATASIZE].
REQ-017 xb_fu_rdy  out  NUM_FU  per-FU result accepted this cycle.
REQ-018 ps_bc_wen  in  1  bus-connect write request.
REQ-019 ps_bc_wadd  in  ADDRESS_WIDTH  bus-connect write address.
REQ-020 bc_dt  in  RF_DATASIZE  bus-connect write data.
REQ-021 xb_bc_rdy  out  1  bus-connect write accepted this cycle.

Function
REQ-022 State: register array, busy bit per register, pending bit and pending address per FU.
REQ-023 Stall = ps_iss_vld and any of: busy[raddx], busy[raddy], busy[wadd] (WAW), pending of selected FU, ps_iss_fu not one-hot.
REQ-024 Accepted issue (vld, no stall): next edge sets busy[wadd], sets pending[fu], records wadd as pending address.
REQ-025 One RF write per cycle; priority: bus-connect, then lowest-index FU whose vld is set and pending is set.
REQ-026 xb_bc_rdy = ps_bc_wen and not busy[ps_bc_wadd]; accepted write commits at next edge.
REQ-027 xb_fu_rdy[i] high only for the granted FU; granted result writes its pending address and clears that busy and pending bit at the same edge.
REQ-028 fu_xb_vld[i] with pending[i] low: xb_fu_rdy[i] high immediately, data discarded, no write, no grant consumed.
REQ-029 Ungranted FUs wait; result data and vld held by FU; no starvation guarantee beyond fixed priority.
REQ-030 Issue and writeback in same cycle both apply; issue to the FU completing this cycle still stalls (pending checked pre-edge).
REQ-031 Without bypass, data written at edge N is visible on xb_dtx/xb_dty from cycle N+1; read-to-write latency 1 cycle.
REQ-032 cu_ps_idle combinational: all busy and pending bits clear.

Reset
REQ-033 reset low: all busy/pending bits 0, all registers 0 asynchronously; outputs then: cu_ps_stall 0, cu_ps_idle 1, xb_dtx/xb_dty 0, xb_fu_rdy reflects only REQ-028.
REQ-034 Reset mid-operation discards outstanding ops; late FU results are handled per REQ-028.

Configuration
REQ-035 Macro CU_RF_BYPASS_EN defined: a register being written this cycle (bc or FU grant) is forwarded to xb_dtx/xb_dty and excluded from the busy check in REQ-023; issue with wadd equal to that register sets busy (set wins over clear).
REQ-036 CU_RF_BYPASS_EN undefined: no forwarding; dependent issue stalls one extra cycle until cleared busy bit is registered.

Verification
REQ-037 Reset, bc write 0x1234 to r3, next cycle raddx=3 -> xb_dtx=0x1234, cu_ps_idle=1.
REQ-038 Issue FU1 wadd=r5; next cycle issue raddy=5 -> cu_ps_stall=1 until FU1 result 0x00AA accepted; bypass: stall drops in grant cycle with xb_dty=0x00AA; no bypass: one cycle later.
REQ-039 FU0 and FU2 vld same cycle with bc write -> xb_bc_rdy=1, rdy0 next cycle, rdy2 the cycle after; three registers written in order.
REQ-040 Issue FU0 twice back-to-back (r1, r2) -> second stalls until FU0 result accepted.
REQ-041 Issue FU2 wadd=r7, assert reset low mid-op, release, FU2 vld with 0xBEEF -> rdy2=1, r7 reads 0, cu_ps_idle=1.
